// File: rtl/ef_i2s_tx_pkg.sv
// Shared constants, slot type and sample alignment helper for the I2S transmitter.
package ef_i2s_tx_pkg;

    localparam int unsigned SLOT_BITS  = 32;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned FIFO_AW    = 4;

    localparam logic [1:0] CH_LEFT   = 2'b10;
    localparam logic [1:0] CH_RIGHT  = 2'b01;
    localparam logic [1:0] CH_STEREO = 2'b11;

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_e;

    // MSB-align an LSB-aligned sample of 'size' bits (0 means a full 32-bit word).
    function automatic logic [SLOT_BITS-1:0] align_sample(input logic [SLOT_BITS-1:0] data,
                                                          input logic [4:0]           size);
        logic [5:0] amt;
        amt = (size == 5'd0) ? 6'd0 : 6'd32 - {1'b0, size};
        return data << amt;
    endfunction

endpackage

// File: rtl/ef_i2s_tx_fifo.sv
// Sample FIFO: registered storage, combinational read data at the read pointer.
module i2s_tx_fifo #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic          rd,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int unsigned DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic          wr_ok, rd_ok;

    always_comb begin
        full    = (level_q == FULL_LVL);
        empty   = (level_q == '0);
        rd_ok   = rd && !empty;
        // A pop in the same cycle frees a slot, so a write while full still lands.
        wr_ok   = wr && (!full || rd_ok);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (wr_ok) wptr_d = wptr_q + 1'b1;
        if (rd_ok) rptr_d = rptr_q + 1'b1;
        if (wr_ok && !rd_ok) level_d = level_q + 1'b1;
        else if (rd_ok && !wr_ok) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wptr_q] <= wdata;
    end

    assign rdata = mem_q[rptr_q];
    assign level = level_q;

endmodule

// File: rtl/ef_i2s_tx.sv
// I2S / left-justified serial audio transmitter with a 16-entry sample FIFO.
module ef_i2s_tx
    import ef_i2s_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        ws,
    output logic        sck,
    output logic        sdo,
    input  logic        fifo_wr,
    input  logic [31:0] fifo_wdata,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic [4:0]  fifo_level,
    input  logic [4:0]  fifo_level_threshold,
    output logic        fifo_level_below,
    output logic        underflow,
    input  logic        underflow_clr,
    input  logic        left_justified,
    input  logic [4:0]  sample_size,
    input  logic [7:0]  sck_prescaler,
    input  logic [1:0]  channels,
    input  logic        en
);

    logic [7:0]  prescaler_q, prescaler_d;
    logic        sck_q, sck_d;
    logic [4:0]  bit_ctr_q, bit_ctr_d;
    logic        ws_q, ws_d;
    logic        sdo_q, sdo_d;
    logic        lj_bit_q, lj_bit_d;
    logic [31:0] shift_q, shift_d;
    logic        underflow_q, underflow_d;

    logic        tick, fall, boundary, chan_on, fifo_rd, uf_set;
    logic [31:0] load;
    logic [31:0] fifo_rdata;
    slot_e       next_slot;

    i2s_tx_fifo #(
        .DW (SLOT_BITS),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (fifo_wr),
        .wdata (fifo_wdata),
        .rd    (fifo_rd),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        tick        = en && (prescaler_q == '0);
        fall        = tick && sck_q;
        boundary    = fall && (bit_ctr_q == '0);
        next_slot   = ws_q ? SLOT_LEFT : SLOT_RIGHT;
        chan_on     = (next_slot == SLOT_LEFT) ? channels[1] : channels[0];
        fifo_rd     = boundary && chan_on && !fifo_empty;
        uf_set      = boundary && chan_on && fifo_empty;

        prescaler_d = prescaler_q;
        sck_d       = sck_q;
        bit_ctr_d   = bit_ctr_q;
        ws_d        = ws_q;
        sdo_d       = sdo_q;
        lj_bit_d    = lj_bit_q;
        shift_d     = shift_q;
        load        = shift_q;

        if (en) prescaler_d = tick ? sck_prescaler : prescaler_q - 8'd1;
        if (tick) sck_d = ~sck_q;

        // The freshly loaded word's MSB leaves on the same fall that flips ws;
        // I2S mode simply replays the left-justified stream one fall later.
        if (fall) begin
            bit_ctr_d = bit_ctr_q + 5'd1;
            if (boundary) begin
                ws_d = (next_slot == SLOT_RIGHT);
                load = fifo_rd ? align_sample(fifo_rdata, sample_size) : '0;
            end
            lj_bit_d = load[31];
            shift_d  = load << 1;
            sdo_d    = left_justified ? load[31] : lj_bit_q;
        end

        underflow_d = uf_set ? 1'b1 : (underflow_clr ? 1'b0 : underflow_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q <= '0;
            sck_q       <= 1'b0;
            bit_ctr_q   <= '0;
            ws_q        <= 1'b1;
            sdo_q       <= 1'b0;
            lj_bit_q    <= 1'b0;
            shift_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            sck_q       <= sck_d;
            bit_ctr_q   <= bit_ctr_d;
            ws_q        <= ws_d;
            sdo_q       <= sdo_d;
            lj_bit_q    <= lj_bit_d;
            shift_q     <= shift_d;
            underflow_q <= underflow_d;
        end
    end

    assign ws               = ws_q;
    assign sck              = sck_q;
    assign sdo              = sdo_q;
    assign underflow        = underflow_q;
    assign fifo_level_below = (fifo_level < fifo_level_threshold);

endmodule

// File: tb/tb_ef_i2s_tx.sv
// Bench for ef_i2s_tx: directed and random stimulus against a timing/queue reference model.
module tb_ef_i2s_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ws, sck, sdo;
    logic        fifo_wr;
    logic [31:0] fifo_wdata;
    logic        fifo_full, fifo_empty;
    logic [4:0]  fifo_level;
    logic [4:0]  fifo_level_threshold;
    logic        fifo_level_below;
    logic        underflow, underflow_clr;
    logic        left_justified;
    logic [4:0]  sample_size;
    logic [7:0]  sck_prescaler;
    logic [1:0]  channels;
    logic        en;

    always #5 clk = ~clk;

    ef_i2s_tx dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ws                   (ws),
        .sck                  (sck),
        .sdo                  (sdo),
        .fifo_wr              (fifo_wr),
        .fifo_wdata           (fifo_wdata),
        .fifo_full            (fifo_full),
        .fifo_empty           (fifo_empty),
        .fifo_level           (fifo_level),
        .fifo_level_threshold (fifo_level_threshold),
        .fifo_level_below     (fifo_level_below),
        .underflow            (underflow),
        .underflow_clr        (underflow_clr),
        .left_justified       (left_justified),
        .sample_size          (sample_size),
        .sck_prescaler        (sck_prescaler),
        .channels             (channels),
        .en                   (en)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: enabled-edge count drives sck/fall/slot timing arithmetically;
    // FIFO is a queue; every started slot records the word it transmits.
    int          m_c;
    int          m_slots;
    bit [31:0]   m_q[$];
    bit [31:0]   m_words[$];
    bit          m_uf;

    function automatic int ticks_for(int c);
        return (c == 0) ? 0 : (c - 1) / (int'(sck_prescaler) + 1) + 1;
    endfunction

    function automatic int slots_for(int falls);
        return (falls + 31) / 32;
    endfunction

    function automatic bit [31:0] ref_align(bit [31:0] w, bit [4:0] size);
        int unsigned n;
        bit [63:0]   x;
        n = (size == 0) ? 32 : int'(size);
        x = {32'd0, w} & ((64'd1 << n) - 64'd1);
        x = x << (32 - n);
        return x[31:0];
    endfunction

    function automatic bit lj_bit(int f);
        bit [31:0] w;
        w = m_words[f / 32];
        return w[31 - (f % 32)];
    endfunction

    function automatic bit would_boundary();
        return slots_for(ticks_for(m_c + 1) / 2) > m_slots;
    endfunction

    task automatic model_reset();
        m_c = 0;
        m_slots = 0;
        m_q.delete();
        m_words.delete();
        m_uf = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_all();
        int t, falls, lvl;
        bit exp_sdo;
        t     = ticks_for(m_c);
        falls = t / 2;
        lvl   = m_q.size();
        if (falls == 0) exp_sdo = 1'b0;
        else if (left_justified) exp_sdo = lj_bit(falls - 1);
        else exp_sdo = (falls == 1) ? 1'b0 : lj_bit(falls - 2);
        chk("sck", 32'(sck), 32'(t % 2));
        chk("ws", 32'(ws), 32'(m_slots % 2 == 0));
        chk("sdo", 32'(sdo), 32'(exp_sdo));
        chk("fifo_level", 32'(fifo_level), 32'(lvl));
        chk("fifo_empty", 32'(fifo_empty), 32'(lvl == 0));
        chk("fifo_full", 32'(fifo_full), 32'(lvl == 16));
        chk("fifo_level_below", 32'(fifo_level_below), 32'(lvl < int'(fifo_level_threshold)));
        chk("underflow", 32'(underflow), 32'(m_uf));
    endtask

    // One clock: model consumes the inputs sampled at posedge, outputs checked at negedge.
    task automatic step();
        int  ns, s;
        bit  chen, set;
        @(posedge clk);
        set = 1'b0;
        if (en) begin
            m_c++;
            ns = slots_for(ticks_for(m_c) / 2);
            if (ns > m_slots) begin
                s = m_slots;
                m_slots = ns;
                chen = (s % 2 == 0) ? channels[1] : channels[0];
                if (chen && m_q.size() > 0) m_words.push_back(ref_align(m_q.pop_front(), sample_size));
                else begin
                    m_words.push_back(32'd0);
                    if (chen) set = 1'b1;
                end
            end
        end
        if (set) m_uf = 1'b1;
        else if (underflow_clr) m_uf = 1'b0;
        if (fifo_wr && m_q.size() < 16) m_q.push_back(fifo_wdata);
        @(negedge clk);
        check_all();
    endtask

    task automatic run_clks(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write_word(input logic [31:0] w);
        fifo_wr = 1'b1;
        fifo_wdata = w;
        step();
        fifo_wr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 1'b0;
        fifo_wr = 1'b0;
        underflow_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_to_boundary(input string tag, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            if (would_boundary()) hit = 1'b1;
            else step();
        end
        if (!hit) begin
            checks++;
            errors++;
            $error("FAIL %s observed=timeout expected=boundary", tag);
        end
    endtask

    initial begin
        bit hit;
        int k, p;
        rst_n = 1'b0;
        en = 1'b0;
        fifo_wr = 1'b0;
        fifo_wdata = '0;
        underflow_clr = 1'b0;
        fifo_level_threshold = 5'd0;
        left_justified = 1'b1;
        sample_size = 5'd16;
        sck_prescaler = 8'd1;
        channels = 2'b11;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // LJ, 16-bit stereo, sck period 4 clk
        do_reset();
        sck_prescaler = 8'd1; left_justified = 1'b1; sample_size = 5'd16; channels = 2'b11;
        write_word(32'h0000A5A5);
        write_word(32'h00001234);
        en = 1'b1;
        run_clks(2 * 128 + 20);

        // Same stimulus in I2S mode
        do_reset();
        left_justified = 1'b0;
        write_word(32'h0000A5A5);
        write_word(32'h00001234);
        en = 1'b1;
        run_clks(2 * 128 + 20);

        // Left channel only
        do_reset();
        sck_prescaler = 8'd0; left_justified = 1'b1; sample_size = 5'd8; channels = 2'b10;
        fifo_level_threshold = 5'd2;
        write_word(32'h00000001);
        write_word(32'h00000002);
        en = 1'b1;
        run_clks(4 * 64 + 10);

        // Underflow on empty FIFO; clear coinciding with a boundary loses to the set
        do_reset();
        channels = 2'b11; sample_size = 5'd0;
        en = 1'b1;
        run_to_boundary("uf_first_boundary", hit);
        step();
        run_to_boundary("uf_second_boundary", hit);
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        run_clks(10);
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        run_clks(10);

        // Fill past full, then write exactly on a pop while full
        do_reset();
        fifo_level_threshold = 5'd4; sample_size = 5'd0; sck_prescaler = 8'd0; channels = 2'b11;
        for (int i = 0; i < 17; i++) write_word($urandom);
        en = 1'b1;
        run_to_boundary("full_pop_boundary", hit);
        fifo_wr = 1'b1;
        fifo_wdata = 32'h0000BEEF;
        step();
        fifo_wr = 1'b0;
        run_clks(18 * 64 + 10);

        // Enable gap mid-slot, then reset mid-slot
        do_reset();
        sck_prescaler = 8'd2; sample_size = 5'd12; left_justified = 1'b0; channels = 2'b11;
        for (int i = 0; i < 3; i++) write_word($urandom);
        en = 1'b1;
        run_clks(100);
        en = 1'b0;
        run_clks(50);
        en = 1'b1;
        run_clks(2 * 192 + 20);
        do_reset();
        run_clks(5);

        // Randomised configurations with sparse writes, enable gaps and clears
        for (int it = 0; it < 6; it++) begin
            do_reset();
            p = $urandom_range(0, 2);
            sck_prescaler = 8'(p);
            left_justified = 1'($urandom_range(0, 1));
            sample_size = 5'($urandom_range(0, 31));
            channels = 2'($urandom_range(0, 3));
            fifo_level_threshold = 5'($urandom_range(0, 16));
            k = $urandom_range(0, 5);
            for (int i = 0; i < k; i++) write_word($urandom);
            for (int i = 0; i < 3 * 64 * (p + 1) + 20; i++) begin
                en = ($urandom_range(0, 7) != 0);
                fifo_wr = ($urandom_range(0, 15) == 0);
                fifo_wdata = $urandom;
                underflow_clr = ($urandom_range(0, 15) == 0);
                step();
            end
            fifo_wr = 1'b0;
            underflow_clr = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ef_i2s_tx.md
EF_I2S_TX -- requirements
Module: EF_I2S_TX

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, with ports clk and rst_n.
REQ-002 The ports SHALL be, in order:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- ws  out  1  word select, 0 = left slot, 1 = right slot
- sck  out  1  serial clock
- sdo  out  1  serial data
REQ-003 The FIFO ports SHALL be:
- fifo_wr  in  1  write strobe
- fifo_wdata  in  32  LSB-aligned sample
- fifo_full  out  1  FIFO full
- fifo_empty  out  1  FIFO empty
- fifo_level  out  5  entries, 0..16
- fifo_level_threshold  in  5  watermark
- fifo_level_below  out  1  fifo_level < fifo_level_threshold
REQ-004 The status and configuration ports SHALL be:
- underflow  out  1  sticky, slot started with FIFO empty
- underflow_clr  in  1  clears underflow
- left_justified  in  1  1 = LJ, 0 = I2S
- sample_size  in  5  bits per sample, 0 = 32
- sck_prescaler  in  8  half-period minus 1, in clk cycles
- channels  in  2  10 = left, 01 = right, 11 = stereo
- en  in  1  enable

Function
REQ-005 Prescaler: while en=1, prescaler=0 reloads sck_prescaler, otherwise it decrements; tick = en & (prescaler==0).
REQ-006 On tick, sck SHALL toggle; fall = tick & sck==1 (falling edge); a 5-bit bit_ctr SHALL increment on fall and wrap 31->0.
REQ-007 Boundary = fall & bit_ctr==0; ws SHALL toggle on boundary, giving 32 sck periods per slot; the new slot is left if the old ws was 1.
REQ-008 On boundary, if the new slot's channel bit is set (left=channels[1], right=channels[0]) and the FIFO is not empty, the block SHALL pop exactly one entry in that clk and load shift = wdata << (32-N), where N = sample_size, or 32 if sample_size=0; bits above N-1 are ignored.
REQ-009 On boundary with the channel enabled and the FIFO empty, the block SHALL load zeros, set underflow, and not pop.
REQ-010 On boundary with the channel disabled, the block SHALL load zeros and not pop; channels=00 SHALL pop nothing.
REQ-011 LJ mode: on each fall, sdo <= shift[31] and shift <<= 1, so the MSB is driven on the same fall that toggles ws.
REQ-012 I2S mode: sdo SHALL be the LJ bit stream delayed by one fall, so the MSB appears one sck after the ws change; the slot's 32nd bit spills into the first bit of the next slot.
REQ-013 sdo SHALL change only on falls, so it is stable at every sck rising edge.
REQ-014 The FIFO SHALL be 16 x 32-bit with r_data combinational from the read pointer.
REQ-015 A write while full SHALL be dropped, unless a pop occurs in the same clk, in which case it is accepted.
REQ-016 A pop and a write in the same clk while empty SHALL give underflow with the write accepted; there is no bypass.
REQ-017 When en=0, prescaler, sck, bit_ctr, ws, shift and sdo SHALL hold; the FIFO SHALL still accept writes.
REQ-018 underflow_clr SHALL clear underflow; if a set and a clear coincide, set wins.
REQ-019 Config changes SHALL take effect at the next boundary; sample_size and left_justified changed mid-slot are undefined for that slot only.

Reset
REQ-020 Reset values SHALL be: prescaler=0, sck=0, bit_ctr=0, ws=1, sdo=0, shift=0, underflow=0, fifo_empty=1, fifo_full=0, fifo_level=0.
REQ-021 Reset asserted mid-slot SHALL return all state to the reset values immediately, discard FIFO contents and keep ws=1.

Structure
REQ-022 A shared package SHALL hold SLOT_BITS=32, FIFO_DEPTH=16, FIFO_AW=4 and the channel encodings CH_LEFT=2'b10, CH_RIGHT=2'b01, CH_STEREO=2'b11.
REQ-023 The design SHALL have one sub-module, i2s_tx_fifo (parameterised DW/AW, level output AW+1 bits); all other logic stays in the top.

Verification
REQ-024 prescaler=1, LJ, N=16, stereo, write 0x0000A5A5 then 0x00001234, en=1 -> sck period 4 clk, slot 128 clk; left slot sdo = A5A5 MSB-first followed by 16 zeros; right slot = 1234 followed by 16 zeros.
REQ-025 Same stimulus with I2S mode -> identical bits, each delayed by one sck after the ws edge.
REQ-026 channels=10, write 0x1, 0x2 -> pops only at left slots; right slots carry zeros; fifo_level goes 2->1->0 over 2 frames.
REQ-027 Empty FIFO, stereo, en=1 -> sdo=0, underflow=1 at the first boundary; underflow_clr pulse coinciding with the next boundary -> underflow stays 1.
REQ-028 Write 17 entries -> fifo_full=1, fifo_level=16, 17th entry dropped; with fifo_level_threshold=4, fifo_level_below rises when the level drops to 3.
REQ-029 Deassert en mid-slot for 50 clk, then reassert -> sck, ws and sdo frozen during the gap, then the bit sequence resumes without loss; assert rst_n=0 mid-slot -> all outputs at reset values within 1 clk.
